// File: rtl/pulse_decoder_3x8.sv
// Binary-to-one-hot strobe decoder: each accepted code drives one line of y for
// PULSE_LEN cycles, followed by GAP_LEN forced-zero cycles, with one code of lookahead.
module pulse_decoder_3x8 #(
    parameter int N_IN      = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_code,
    output logic                 in_ready,
    output logic [2**N_IN-1:0]   y,
    output logic                 busy,
    output logic                 done
);

    localparam int W       = 2 ** N_IN;
    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                                   : ((GAP_LEN > 2) ? GAP_LEN : 2);
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     y_r;
    logic             busy_r;
    logic             done_r;
    logic             pend_valid_r;
    logic [N_IN-1:0]  pend_code_r;

    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [W-1:0]     y_nx_s;
    logic             done_nx_s;
    logic             pend_valid_nx_s;
    logic [N_IN-1:0]  pend_code_nx_s;
    logic             xfer_s;
    logic             have_next_s;
    logic [N_IN-1:0]  next_code_s;

    function automatic logic [W-1:0] onehot_f(input logic [N_IN-1:0] code);
        onehot_f = W'(1) << code;
    endfunction

    assign in_ready    = rst_n & en & ~pend_valid_r;
    assign xfer_s      = in_valid & in_ready;
    // A held pending code always takes precedence over a fresh transfer.
    assign have_next_s = pend_valid_r | xfer_s;
    assign next_code_s = pend_valid_r ? pend_code_r : in_code;

    assign y    = y_r;
    assign busy = busy_r;
    assign done = done_r;

    // Next-state logic for the pulse/gap sequencer and the pending slot.
    always_comb begin
        state_nx_s      = state_r;
        cnt_nx_s        = cnt_r;
        y_nx_s          = y_r;
        done_nx_s       = 1'b0;
        pend_valid_nx_s = pend_valid_r;
        pend_code_nx_s  = pend_code_r;
        if (!en) begin
            state_nx_s      = ST_IDLE;
            cnt_nx_s        = CNT_ZERO;
            y_nx_s          = {W{1'b0}};
            pend_valid_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    y_nx_s = {W{1'b0}};
                    if (xfer_s) begin
                        state_nx_s = ST_ACTIVE;
                        cnt_nx_s   = PULSE_LOAD;
                        y_nx_s     = onehot_f(in_code);
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                        if (xfer_s) begin
                            pend_valid_nx_s = 1'b1;
                            pend_code_nx_s  = in_code;
                        end else begin
                            pend_valid_nx_s = pend_valid_r;
                        end
                    end else begin
                        y_nx_s    = {W{1'b0}};
                        done_nx_s = 1'b1;
                        if (GAP_LEN > 0) begin
                            state_nx_s = ST_GAP;
                            cnt_nx_s   = GAP_LOAD;
                            if (xfer_s) begin
                                pend_valid_nx_s = 1'b1;
                                pend_code_nx_s  = in_code;
                            end else begin
                                pend_valid_nx_s = pend_valid_r;
                            end
                        end else if (have_next_s) begin
                            state_nx_s      = ST_ACTIVE;
                            cnt_nx_s        = PULSE_LOAD;
                            y_nx_s          = onehot_f(next_code_s);
                            pend_valid_nx_s = 1'b0;
                        end else begin
                            state_nx_s = ST_IDLE;
                            cnt_nx_s   = CNT_ZERO;
                        end
                    end
                end
                ST_GAP: begin
                    y_nx_s = {W{1'b0}};
                    if (cnt_r != CNT_ZERO) begin
                        cnt_nx_s = cnt_r - CNT_ONE;
                        if (xfer_s) begin
                            pend_valid_nx_s = 1'b1;
                            pend_code_nx_s  = in_code;
                        end else begin
                            pend_valid_nx_s = pend_valid_r;
                        end
                    end else if (have_next_s) begin
                        state_nx_s      = ST_ACTIVE;
                        cnt_nx_s        = PULSE_LOAD;
                        y_nx_s          = onehot_f(next_code_s);
                        pend_valid_nx_s = 1'b0;
                    end else begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_nx_s      = ST_IDLE;
                    cnt_nx_s        = CNT_ZERO;
                    y_nx_s          = {W{1'b0}};
                    pend_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter, pending slot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            y_r          <= {W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_code_r  <= {N_IN{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            y_r          <= y_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            done_r       <= done_nx_s;
            pend_valid_r <= pend_valid_nx_s;
            pend_code_r  <= pend_code_nx_s;
        end
    end

endmodule

// File: tb/tb_pulse_decoder_3x8.sv
// Randomized scoreboard bench for pulse_decoder_3x8: a default instance and a GAP_LEN=0
// instance share stimulus; a cycle-schedule model predicts every output each cycle.
module tb_pulse_decoder_3x8;

    localparam int PL = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;
    logic       r0, r1, b0, b1, d0, d1;
    logic [7:0] y0, y1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] y0; logic b0; logic d0; logic r0;
        logic [7:0] y1; logic b1; logic d1; logic r1;
    } snap_t;

    snap_t exp_q[$];

    pulse_decoder_3x8 u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(r0), .y(y0), .busy(b0), .done(d0)
    );

    pulse_decoder_3x8 #(.N_IN(3), .PULSE_LEN(4), .GAP_LEN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(r1), .y(y1), .busy(b1), .done(d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: a pulse launched at cycle L is one-hot on L..L+PL-1, done at L+PL,
    // busy until L+PL+G-1; the next launch may happen on the edge into cycle L+PL+G.
    int         cyc = 0;
    bit         have[2];
    int         lst[2];
    int         pend_n[2];
    logic [2:0] pend_c[2];
    logic [2:0] cur[2];
    logic [7:0] ey[2];
    logic       eb[2], ed[2], er[2];

    task automatic model_step(input int d, input int g);
        bit xfer;
        int e;
        logic [7:0] one;
        e = cyc;
        one = 8'd1;
        xfer = in_valid && rst_n && en && (pend_n[d] == 0);
        ed[d] = 1'b0;
        if (!rst_n || !en) begin
            have[d]   = 1'b0;
            pend_n[d] = 0;
        end else begin
            if (have[d] && e == lst[d] + PL) ed[d] = 1'b1;
            if (!have[d] || e >= lst[d] + PL + g) begin
                if (pend_n[d] > 0) begin
                    cur[d] = pend_c[d]; pend_n[d] = 0; lst[d] = e; have[d] = 1'b1;
                end else if (xfer) begin
                    cur[d] = in_code; lst[d] = e; have[d] = 1'b1;
                end else begin
                    have[d] = 1'b0;
                end
            end else if (xfer) begin
                pend_c[d] = in_code;
                pend_n[d] = 1;
            end
        end
        ey[d] = (have[d] && e < lst[d] + PL) ? (one << cur[d]) : 8'd0;
        eb[d] = have[d] && (e < lst[d] + PL + g);
        er[d] = rst_n && en && (pend_n[d] == 0);
    endtask

    initial begin
        snap_t s;
        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0; lst[i] = -100; pend_n[i] = 0; pend_c[i] = 3'd0; cur[i] = 3'd0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, 1);
            model_step(1, 0);
            s = '{y0: ey[0], b0: eb[0], d0: ed[0], r0: er[0],
                  y1: ey[1], b1: eb[1], d1: ed[1], r1: er[1]};
            exp_q.push_back(s);
        end
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("queue_empty", 8'd0, 8'd1);
            end else begin
                s = exp_q.pop_front();
                chk("dut0_y", y0, s.y0);
                chk("dut0_busy", {7'd0, b0}, {7'd0, s.b0});
                chk("dut0_done", {7'd0, d0}, {7'd0, s.d0});
                chk("dut0_ready", {7'd0, r0}, {7'd0, s.r0});
                chk("dut1_y", y1, s.y1);
                chk("dut1_busy", {7'd0, b1}, {7'd0, s.b1});
                chk("dut1_done", {7'd0, d1}, {7'd0, s.d1});
                chk("dut1_ready", {7'd0, r1}, {7'd0, s.r1});
                if (b0 && y0 != 8'd0) chk("dut0_onehot", {7'd0, $onehot(y0)}, 8'd1);
                if (b1 && y1 != 8'd0) chk("dut1_onehot", {7'd0, $onehot(y1)}, 8'd1);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] c, input logic e);
        @(negedge clk);
        #1;
        in_valid = v;
        in_code  = c;
        en       = e;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = 3'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b1);

        // Single code 5.
        drive(1'b1, 3'd5, 1'b1);
        repeat (8) drive(1'b0, 3'd0, 1'b1);

        // Back-to-back 7 then 0, with code 0 held on the bus.
        drive(1'b1, 3'd7, 1'b1);
        repeat (6) drive(1'b1, 3'd0, 1'b1);
        repeat (8) drive(1'b0, 3'd1, 1'b1);

        // Abort a code-3 pulse while code 4 is pending.
        drive(1'b1, 3'd3, 1'b1);
        drive(1'b1, 3'd4, 1'b1);
        drive(1'b1, 3'd6, 1'b1);
        repeat (3) drive(1'b1, 3'd2, 1'b0);
        repeat (3) drive(1'b0, 3'd0, 1'b1);

        // Asynchronous reset in the middle of a pulse.
        drive(1'b1, 3'd6, 1'b1);
        drive(1'b0, 3'd0, 1'b1);
        drive(1'b0, 3'd0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_y0", y0, 8'd0);
        chk("async_rst_busy0", {7'd0, b0}, 8'd0);
        chk("async_rst_ready0", {7'd0, r0}, 8'd0);
        chk("async_rst_y1", y1, 8'd0);
        chk("async_rst_busy1", {7'd0, b1}, 8'd0);
        chk("async_rst_ready1", {7'd0, r1}, 8'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b1);

        // Random sweep: codes toggle every cycle, rare enable drops.
        repeat (3000) begin
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0);
        end
        repeat (4) drive(1'b0, 3'd0, 1'b1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
